gol_sequencer: RTL
==================

GOL_SEQUENCER -- requirements
Module: gol_sequencer

Interface
REQ-001 Parameter FIELD_W, default 5, field width in cells; passed to the loader and stepper it controls.
REQ-002 Parameter FIELD_H, default 3, field height in cells.
REQ-003 Parameter TICK_DIV, default 4, clock cycles per generation period; legal range 1..65535.
REQ-004 Parameter ARM_TIMEOUT, default 8, maximum cycles to wait for a started unit to raise busy.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_start  input  1  request to (re)load the configuration and run; sampled per cycle.
REQ-008 i_stop  input  1  request to return to idle; sampled per cycle.
REQ-009 i_pause  input  1  level; while high, free-running generation ticks are suppressed.
REQ-010 i_step  input  1  single-step request; honoured only while i_pause is high.
REQ-011 o_load_go  output  1  one-cycle start pulse to the field config loader.
REQ-012 i_is_loading  input  1  loader busy flag.
REQ-013 o_step_go  output  1  one-cycle start pulse to the generation stepper.
REQ-014 i_step_busy  input  1  stepper busy flag.
REQ-015 o_mem_sel  output  2  field-memory owner: 0 display, 1 loader, 2 stepper; 3 is never driven.
REQ-016 o_gen_count  output  16  generations completed since the last load.
REQ-017 o_running  output  1  high in every state except IDLE.
REQ-018 o_error  output  1  sticky arm-timeout flag.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD_ARM, LOADING, RUN_WAIT, STEP_ARM and STEPPING; all outputs SHALL be registered.
REQ-020 In IDLE, i_start=1 SHALL move the FSM to LOAD_ARM, clear o_gen_count and o_error, and drive o_load_go=1 for exactly the next cycle.
REQ-021 In LOAD_ARM, i_is_loading=1 SHALL move the FSM to LOADING; ARM_TIMEOUT cycles without it SHALL move the FSM to IDLE and set o_error.
REQ-022 In LOADING, i_is_loading=0 SHALL move the FSM to RUN_WAIT and load the tick counter with TICK_DIV-1.
REQ-023 o_mem_sel SHALL be 1 in LOAD_ARM and LOADING, 2 in STEP_ARM and STEPPING, and 0 in all other states; it SHALL change on the same edge as the state.
REQ-024 In RUN_WAIT with i_pause=0, the tick counter SHALL decrement each cycle; in the cycle it reads 0, the FSM SHALL move to STEP_ARM and drive o_step_go=1 for one cycle.
REQ-025 In RUN_WAIT with i_pause=1, the counter SHALL hold; i_step=1 SHALL trigger STEP_ARM and o_step_go as in REQ-024.
REQ-026 STEP_ARM SHALL behave like LOAD_ARM, using i_step_busy.
REQ-027 In STEPPING, i_step_busy=0 SHALL increment o_gen_count (wrapping 16'hFFFF to 0), reload the counter with TICK_DIV-1, and return the FSM to RUN_WAIT.
REQ-028 In RUN_WAIT, i_start SHALL restart the sequence exactly as REQ-020; it SHALL take priority over i_stop, which in turn takes priority over a tick or step.
REQ-029 i_stop or i_start seen in LOAD_ARM, LOADING, STEP_ARM or STEPPING SHALL be latched as pending and acted on in the first RUN_WAIT cycle; start wins if both are pending.
REQ-030 i_stop in IDLE SHALL be ignored; i_step with i_pause=0 SHALL be ignored.
REQ-031 TICK_DIV=1 SHALL produce a step request in the first RUN_WAIT cycle after every load or step.

Reset
REQ-032 rst_n=0 at any time, including mid-load or mid-step, SHALL immediately force: state IDLE, o_load_go=0, o_step_go=0, o_mem_sel=0, o_gen_count=0, o_running=0, o_error=0, counter=0, and no pending requests.

Verification
REQ-033 Start -> o_load_go pulses once; loader busy for 15 cycles -> o_mem_sel=1 throughout, then RUN_WAIT; o_step_go pulses 4 cycles after RUN_WAIT entry.
REQ-034 Three free-running steps, each with busy for 15 cycles -> o_gen_count=3; o_step_go spacing = 4 + 15 + arm/handshake overhead, constant across steps.
REQ-035 Pause held 20 cycles -> no o_step_go; then an i_step pulse -> exactly one step, o_gen_count increments by 1.
REQ-036 i_stop asserted mid-STEPPING -> step completes, o_gen_count increments, then IDLE, o_running=0, o_mem_sel=0.
REQ-037 Loader never raises busy -> IDLE after 8 cycles, o_error=1; a subsequent i_start clears o_error.
REQ-038 rst_n pulsed low mid-LOADING -> all outputs at reset values asynchronously; after release, FSM stays in IDLE until i_start.

Source files
------------

// File: rtl/gol_sequencer_if.sv
// Handshake bundle between the Game-of-Life sequencer, its host controls,
// and the field loader / generation stepper it drives.
interface gol_sequencer_if;
  logic        i_start;
  logic        i_stop;
  logic        i_pause;
  logic        i_step;
  logic        o_load_go;
  logic        i_is_loading;
  logic        o_step_go;
  logic        i_step_busy;
  logic [1:0]  o_mem_sel;
  logic [15:0] o_gen_count;
  logic        o_running;
  logic        o_error;

  modport master (
    input  i_start, i_stop, i_pause, i_step, i_is_loading, i_step_busy,
    output o_load_go, o_step_go, o_mem_sel, o_gen_count, o_running, o_error
  );

  modport slave (
    output i_start, i_stop, i_pause, i_step, i_is_loading, i_step_busy,
    input  o_load_go, o_step_go, o_mem_sel, o_gen_count, o_running, o_error
  );
endinterface

// File: rtl/gol_sequencer.sv
// Generation sequencer: loads a field, then paces the stepper with a tick
// divider, supporting pause/single-step, stop/restart and arm timeouts.
module gol_sequencer #(
  parameter int FIELD_W     = 5,
  parameter int FIELD_H     = 3,
  parameter int TICK_DIV    = 4,
  parameter int ARM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  gol_sequencer_if.master  bus
);

  if (FIELD_W < 1 || FIELD_H < 1 || TICK_DIV < 1 || TICK_DIV > 65535 || ARM_TIMEOUT < 1)
  begin : g_param_check
    $error("gol_sequencer: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD_ARM,
    LOADING,
    RUN_WAIT,
    STEP_ARM,
    STEPPING
  } state_t;

  localparam logic [1:0]  MEM_DISPLAY = 2'd0;
  localparam logic [1:0]  MEM_LOADER  = 2'd1;
  localparam logic [1:0]  MEM_STEPPER = 2'd2;
  localparam logic [15:0] TICK_RELOAD = 16'(TICK_DIV - 1);
  localparam logic [15:0] ARM_LAST    = 16'(ARM_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [15:0] tick_reg, tick_next;
  logic [15:0] arm_reg, arm_next;
  logic [15:0] gen_reg, gen_next;
  logic        load_go_reg, load_go_next;
  logic        step_go_reg, step_go_next;
  logic [1:0]  mem_sel_reg, mem_sel_next;
  logic        running_reg, running_next;
  logic        error_reg, error_next;
  logic        pend_start_reg, pend_start_next;
  logic        pend_stop_reg, pend_stop_next;
  logic        unit_busy;

  // The busy flag of whichever unit currently owns the handshake.
  assign unit_busy = (state_reg == LOAD_ARM || state_reg == LOADING) ?
                     bus.i_is_loading : bus.i_step_busy;

  always_comb begin
    state_next      = state_reg;
    tick_next       = tick_reg;
    arm_next        = arm_reg;
    gen_next        = gen_reg;
    error_next      = error_reg;
    pend_start_next = pend_start_reg;
    pend_stop_next  = pend_stop_reg;
    load_go_next    = 1'b0;
    step_go_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.i_start) begin
          state_next   = LOAD_ARM;
          load_go_next = 1'b1;
          gen_next     = 16'd0;
          error_next   = 1'b0;
          arm_next     = 16'd0;
        end
      end

      LOAD_ARM, STEP_ARM: begin
        pend_start_next = pend_start_reg | bus.i_start;
        pend_stop_next  = pend_stop_reg | bus.i_stop;
        if (unit_busy) begin
          state_next = (state_reg == LOAD_ARM) ? LOADING : STEPPING;
        end else if (arm_reg == ARM_LAST) begin
          state_next      = IDLE;
          error_next      = 1'b1;
          pend_start_next = 1'b0;
          pend_stop_next  = 1'b0;
        end else begin
          arm_next = arm_reg + 16'd1;
        end
      end

      LOADING, STEPPING: begin
        pend_start_next = pend_start_reg | bus.i_start;
        pend_stop_next  = pend_stop_reg | bus.i_stop;
        if (!unit_busy) begin
          state_next = RUN_WAIT;
          tick_next  = TICK_RELOAD;
          if (state_reg == STEPPING) begin
            gen_next = gen_reg + 16'd1;
          end
        end
      end

      RUN_WAIT: begin
        // Requests deferred during a busy phase are consumed here, start first.
        pend_start_next = 1'b0;
        pend_stop_next  = 1'b0;
        if (bus.i_start || pend_start_reg) begin
          state_next   = LOAD_ARM;
          load_go_next = 1'b1;
          gen_next     = 16'd0;
          error_next   = 1'b0;
          arm_next     = 16'd0;
        end else if (bus.i_stop || pend_stop_reg) begin
          state_next = IDLE;
        end else if (bus.i_pause ? bus.i_step : (tick_reg == 16'd0)) begin
          state_next   = STEP_ARM;
          step_go_next = 1'b1;
          arm_next     = 16'd0;
        end else if (!bus.i_pause) begin
          tick_next = tick_reg - 16'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory ownership follows the next state so it switches on the same edge.
  always_comb begin
    mem_sel_next = MEM_DISPLAY;
    case (state_next)
      LOAD_ARM, LOADING:  mem_sel_next = MEM_LOADER;
      STEP_ARM, STEPPING: mem_sel_next = MEM_STEPPER;
      default:            mem_sel_next = MEM_DISPLAY;
    endcase
    running_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      tick_reg       <= 16'd0;
      arm_reg        <= 16'd0;
      gen_reg        <= 16'd0;
      load_go_reg    <= 1'b0;
      step_go_reg    <= 1'b0;
      mem_sel_reg    <= MEM_DISPLAY;
      running_reg    <= 1'b0;
      error_reg      <= 1'b0;
      pend_start_reg <= 1'b0;
      pend_stop_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tick_reg       <= tick_next;
      arm_reg        <= arm_next;
      gen_reg        <= gen_next;
      load_go_reg    <= load_go_next;
      step_go_reg    <= step_go_next;
      mem_sel_reg    <= mem_sel_next;
      running_reg    <= running_next;
      error_reg      <= error_next;
      pend_start_reg <= pend_start_next;
      pend_stop_reg  <= pend_stop_next;
    end
  end

  assign bus.o_load_go   = load_go_reg;
  assign bus.o_step_go   = step_go_reg;
  assign bus.o_mem_sel   = mem_sel_reg;
  assign bus.o_gen_count = gen_reg;
  assign bus.o_running   = running_reg;
  assign bus.o_error     = error_reg;

endmodule
